uart_rx_fsm: RTL and testbench

- UART receive stage: the downstream consumer of the serial line driven by the transmit FSM.
- Recovers {start, data LSB-first, stop, stop} frames from RX using a 16x oversampling tick, and presents each byte with a one-cycle valid pulse.
- Sits between the RX pin (after the board-level pad) and the consumer logic that reads received characters.

---
 rtl/uart_rx_fsm_if.sv | 22 ++
 rtl/uart_rx_fsm.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fsm_if.sv
// uart_rx_fsm_if: serial input and received-character outputs of the UART receiver
interface uart_rx_fsm_if #(
    parameter int DATA_BW = 8
);
    logic               tick;
    logic               RX;
    logic [DATA_BW-1:0] data_out;
    logic               valid;
    logic               frame_err;
    logic               parity_err;
    logic               busy;

    modport master (
        output tick, RX,
        input  data_out, valid, frame_err, parity_err, busy
    );

    modport slave (
        input  tick, RX,
        output data_out, valid, frame_err, parity_err, busy
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: oversampled UART receiver for {start, data LSB-first, [parity], stop, stop}; UART_RX_PARITY_EN adds even parity
module uart_rx_fsm #(
    parameter int DATA_BW     = 8,
    parameter int DATA_BW_BIT = 4,
    parameter int OVS         = 16,
    parameter int OVS_BIT     = 4
) (
    input logic          clk,
    input logic          rst,
    uart_rx_fsm_if.slave bus
);
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP_1, STOP_2} state_t;
    localparam state_t AFTER_DATA = PARITY;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP_1, STOP_2} state_t;
    localparam state_t AFTER_DATA = STOP_1;
`endif

    localparam logic [OVS_BIT-1:0]     MID_START = OVS_BIT'(OVS / 2 - 1);
    localparam logic [OVS_BIT-1:0]     MID_BIT   = OVS_BIT'(OVS - 1);
    localparam logic [DATA_BW_BIT-1:0] LAST_BIT  = DATA_BW_BIT'(DATA_BW - 1);

    state_t               state;
    logic [OVS_BIT-1:0]     ovs_cnt;
    logic [DATA_BW_BIT-1:0] bit_cnt;
    logic [DATA_BW-1:0]     shift;
    logic [DATA_BW-1:0]     data_out;
    logic                   ferr;
    logic                   valid;
    logic                   frame_err;
    logic                   busy;
    logic                   rx_m;
    logic                   rx_s;
    logic                   rx_d;
    logic                   fall;
    logic                   mid;
`ifdef UART_RX_PARITY_EN
    logic                   perr;
    logic                   parity_err;
`endif

    assign fall = rx_d & ~rx_s;
    assign mid  = bus.tick && ovs_cnt == MID_BIT;

    // two-flop synchronizer plus one delay stage for start-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= bus.RX;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    // frame FSM; counters restart on every state change, outputs are registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ovs_cnt   <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            ferr      <= 1'b0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr       <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    ovs_cnt <= '0;
                    bit_cnt <= '0;
                    ferr    <= 1'b0;
                    busy    <= fall;
                    state   <= fall ? START : IDLE;
`ifdef UART_RX_PARITY_EN
                    perr <= 1'b0;
`endif
                end
                START: begin
                    if (bus.tick && ovs_cnt == MID_START) begin
                        ovs_cnt <= '0;
                        state   <= rx_s ? IDLE : DATA;
                        busy    <= ~rx_s;
                    end else if (bus.tick) begin
                        ovs_cnt <= ovs_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (mid) begin
                        shift   <= {rx_s, shift[DATA_BW-1:1]};
                        ovs_cnt <= '0;
                        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                        state   <= (bit_cnt == LAST_BIT) ? AFTER_DATA : DATA;
                    end else if (bus.tick) begin
                        ovs_cnt <= ovs_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (mid) begin
                        perr    <= rx_s ^ (^shift);
                        ovs_cnt <= '0;
                        state   <= STOP_1;
                    end else if (bus.tick) begin
                        ovs_cnt <= ovs_cnt + 1'b1;
                    end
                end
`endif
                STOP_1: begin
                    if (mid) begin
                        ferr    <= ferr | ~rx_s;
                        ovs_cnt <= '0;
                        state   <= STOP_2;
                    end else if (bus.tick) begin
                        ovs_cnt <= ovs_cnt + 1'b1;
                    end
                end
                STOP_2: begin
                    if (mid) begin
                        data_out  <= shift;
                        frame_err <= ferr | ~rx_s;
                        valid     <= 1'b1;
                        busy      <= 1'b0;
                        ovs_cnt   <= '0;
                        state     <= IDLE;
`ifdef UART_RX_PARITY_EN
                        parity_err <= perr;
`endif
                    end else if (bus.tick) begin
                        ovs_cnt <= ovs_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ovs_cnt <= '0;
                    bit_cnt <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out  = data_out;
    assign bus.valid     = valid;
    assign bus.frame_err = frame_err;
    assign bus.busy      = busy;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed vector bench for uart_rx_fsm (tick every 4 clk, 64 clk per bit)
module tb_uart_rx_fsm;
    localparam int BIT_CLK = 64;

    typedef struct packed {
        logic [7:0] data;
        logic       par;
        logic       s1;
        logic       s2;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } rec_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   tcnt   = 0;
    logic prev_v = 1'b0;
    logic dbl    = 1'b0;
    rec_t q[$];
    vec_t vec[8];

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    uart_rx_fsm_if #(.DATA_BW(8)) bus ();

    uart_rx_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        bus.tick = 1'b0;
        forever begin
            @(negedge clk);
            bus.tick = (tcnt == 3);
            tcnt = (tcnt + 1) % 4;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.valid) begin
                q.push_back({bus.data_out, bus.frame_err, bus.parity_err});
                if (prev_v) dbl = 1'b1;
            end
            prev_v = bus.valid;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic hold_bit(input logic b);
        bus.RX = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic s1, input logic s2);
        hold_bit(1'b0);
        check("busy_in_frame", {31'b0, bus.busy}, 32'd1);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
        if (PAR_EN) hold_bit(par);
        hold_bit(s1);
        hold_bit(s2);
        bus.RX = 1'b1;
    endtask

    task automatic expect_frame(input string nm, input logic [7:0] d, input logic fe, input logic pe);
        int   n;
        rec_t r;
        n = 0;
        while (q.size() == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s no valid got none want 1", nm);
        end else begin
            r = q.pop_front();
            check({nm, "_data"}, {24'b0, r.data}, {24'b0, d});
            check({nm, "_ferr"}, {31'b0, r.ferr}, {31'b0, fe});
            check({nm, "_perr"}, {31'b0, r.perr}, {31'b0, pe & PAR_EN});
        end
    endtask

    initial begin
        vec[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vec[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0};
        vec[2] = '{8'h55, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};
        vec[3] = '{8'h07, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1};
        vec[4] = '{8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vec[5] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        vec[6] = '{8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        vec[7] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

        rst    = 1'b0;
        bus.RX = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data", {24'b0, bus.data_out}, 32'd0);
        check("rst_valid", {31'b0, bus.valid}, 32'd0);
        check("rst_ferr", {31'b0, bus.frame_err}, 32'd0);
        check("rst_perr", {31'b0, bus.parity_err}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            send_frame(vec[i].data, vec[i].par, vec[i].s1, vec[i].s2);
            expect_frame($sformatf("vec%0d", i), vec[i].exp_data, vec[i].exp_ferr, vec[i].exp_perr);
            check($sformatf("vec%0d_busy_after", i), {31'b0, bus.busy}, 32'd0);
            repeat (20) @(negedge clk);
        end

        bus.RX = 1'b0;
        repeat (12) @(negedge clk);
        bus.RX = 1'b1;
        check("glitch_busy_high", {31'b0, bus.busy}, 32'd1);
        repeat (60) @(negedge clk);
        check("glitch_busy_low", {31'b0, bus.busy}, 32'd0);
        repeat (300) @(negedge clk);
        check("glitch_no_valid", q.size(), 32'd0);
        check("glitch_keeps_data", {24'b0, bus.data_out}, 32'hFF);

        bus.RX = 1'b0;
        repeat (30 * BIT_CLK) @(negedge clk);
        bus.RX = 1'b1;
        check("break_one_frame", q.size(), 32'd1);
        repeat (BIT_CLK) @(negedge clk);
        expect_frame("break", 8'h00, 1'b1, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1, 1'b1);
        expect_frame("after_break", 8'h81, 1'b0, 1'b0);
        repeat (20) @(negedge clk);

        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(1'b0);
        rst = 1'b0;
        #1;
        check("midrst_data", {24'b0, bus.data_out}, 32'd0);
        check("midrst_valid", {31'b0, bus.valid}, 32'd0);
        check("midrst_ferr", {31'b0, bus.frame_err}, 32'd0);
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        repeat (10) @(negedge clk);
        bus.RX = 1'b1;
        rst = 1'b1;
        repeat (8 * BIT_CLK) @(negedge clk);
        check("midrst_no_valid", q.size(), 32'd0);
        check("midrst_busy_idle", {31'b0, bus.busy}, 32'd0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        expect_frame("post_rst", 8'h3C, 1'b0, 1'b0);
        repeat (20) @(negedge clk);

        send_frame(8'h00, 1'b0, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
        expect_frame("b2b_0", 8'h00, 1'b0, 1'b0);
        expect_frame("b2b_1", 8'hFF, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        check("b2b_no_extra", q.size(), 32'd0);
        check("valid_single_cycle", {31'b0, dbl}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
